// File: rtl/key_debounce_jk_if.sv
// ---------------------------------------------------------------------------
// key_debounce_jk_if
//   Groups the push-button conditioner's data signals. clk and rst stay plain
//   ports on the design.
//   key       raw asynchronous push-button level   (master -> slave)
//   set       asynchronous active-low preset of q  (master -> slave)
//   j, k      JK inputs, used on a press pulse     (master -> slave)
//   key_pulse one-clk pulse per debounced press    (slave -> master)
//   q_out     JK flop state                        (slave -> master)
// ---------------------------------------------------------------------------
interface key_debounce_jk_if;
  logic key;
  logic set;
  logic j;
  logic k;
  logic key_pulse;
  logic q_out;

  modport master (output key, set, j, k, input key_pulse, q_out);
  modport slave  (input key, set, j, k, output key_pulse, q_out);
endinterface

// File: rtl/key_debounce_jk.sv
// ---------------------------------------------------------------------------
// key_debounce_jk
//   Push-button conditioner feeding a JK flip-flop. The raw key is passed
//   through a 2-FF synchroniser, polarity-normalised so "pressed" = 1, then
//   debounced: the synced level must differ from the accepted (stable) level
//   for DEBOUNCE_CYCLES consecutive clocks before it is accepted. An
//   idle->pressed acceptance yields a registered one-clk key_pulse, which is
//   the clock enable of the JK flop driving q_out.
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset of all state (dominates set)
//   bus   key_debounce_jk_if.slave: key, set, j, k in; key_pulse, q_out out
// Parameters
//   DEBOUNCE_CYCLES  stable clocks required to accept a level change (>=2)
//   KEY_ACTIVE_LOW   1: key low means pressed; 0: key high means pressed
// ---------------------------------------------------------------------------
module key_debounce_jk #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  key_debounce_jk_if.slave bus
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser flops carry the raw key level; their reset value is the raw
  // idle level so that leaving reset never looks like a press.
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;       // accepted level, 1 = pressed
  logic             stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_pulse_q, key_pulse_d;
  logic             q_out_q, q_out_d;
  logic             pressed_sync;

  assign pressed_sync = sync2_q ^ KEY_ACTIVE_LOW;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sync1_d      = bus.key;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = '0;
    q_out_d      = q_out_q;

    // Counter only runs while the synced level disagrees with the accepted
    // one; any bounce back to the accepted level restarts it from zero.
    if (pressed_sync != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = pressed_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Rising edge of the accepted level, seen one clock after acceptance.
    key_pulse_d = stable_q & ~stable_dly_q;

    case ({bus.j, bus.k})
      2'b01:   q_out_d = 1'b0;
      2'b10:   q_out_d = 1'b1;
      2'b11:   q_out_d = ~q_out_q;
      default: q_out_d = q_out_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= KEY_ACTIVE_LOW;
      sync2_q      <= KEY_ACTIVE_LOW;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      key_pulse_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      key_pulse_q  <= key_pulse_d;
    end
  end

  // JK flop: rst clears, set presets (both asynchronous, rst wins); the
  // press pulse is the clock enable, so pulses while set=0 are ignored.
  always_ff @(posedge clk or negedge rst or negedge bus.set) begin
    if (!rst) begin
      q_out_q <= 1'b0;
    end else if (!bus.set) begin
      q_out_q <= 1'b1;
    end else if (key_pulse_q) begin
      q_out_q <= q_out_d;
    end
  end

  assign bus.key_pulse = key_pulse_q;
  assign bus.q_out     = q_out_q;

endmodule

// File: tb/tb_key_debounce_jk.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_jk
//   Directed bench for key_debounce_jk with DEBOUNCE_CYCLES=8,
//   KEY_ACTIVE_LOW=0. Inputs change 1 ns after a rising edge; outputs are
//   sampled there too. Cycle n = the sample taken after the n-th rising edge
//   following a key change, so a clean press pulses at cycle 2+8+1 = 11 and
//   q_out updates one edge later.
// ---------------------------------------------------------------------------
module tb_key_debounce_jk;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  key_debounce_jk_if bus ();

  key_debounce_jk #(
    .DEBOUNCE_CYCLES (8),
    .KEY_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q(input logic exp, input string name);
    n_vec++;
    if (bus.q_out !== exp) begin
      n_err++;
      $display("FAIL %s: q_out=%b expected %b", name, bus.q_out, exp);
    end
  endtask

  // Press with the given JK inputs, key high for `hold` cycles, observe a
  // 25-cycle window, then let the release debounce and check it is silent.
  task automatic press(input logic jj, input logic kk, input int hold,
                       input int exp_pulses, input int exp_cycle,
                       input string name);
    int pulses = 0;
    int first  = -1;
    bus.j   = jj;
    bus.k   = kk;
    bus.key = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == hold) bus.key = 1'b0;
      if (bus.key_pulse === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    bus.key = 1'b0;
    n_vec++;
    if (pulses != exp_pulses) begin
      n_err++;
      $display("FAIL %s pulse count: got %0d expected %0d", name, pulses, exp_pulses);
    end
    if (exp_pulses > 0) begin
      n_vec++;
      if (first != exp_cycle) begin
        n_err++;
        $display("FAIL %s pulse cycle: got %0d expected %0d", name, first, exp_cycle);
      end
    end
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.key_pulse === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL %s release pulses: got %0d expected 0", name, pulses);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    bus.key = 1'b1;
    bus.set = 1'b1;
    bus.j   = 1'b1;
    bus.k   = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_vec++;
      if (bus.key_pulse !== 1'b0 || bus.q_out !== 1'b0) begin
        n_err++;
        $display("FAIL reset cycle %0d: key_pulse=%b q_out=%b expected 0 0",
                 c, bus.key_pulse, bus.q_out);
      end
    end
    // rst dominates set
    bus.set = 1'b0;
    #1;
    expect_q(1'b0, "reset over set");
    bus.set = 1'b1;
    bus.key = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_vec++;
      if (bus.key_pulse !== 1'b0) begin
        n_err++;
        $display("FAIL idle after reset cycle %0d: key_pulse=%b expected 0", c, bus.key_pulse);
      end
    end
    expect_q(1'b0, "idle q");
  endtask

  task automatic test_clean_press();
    press(1'b1, 1'b1, 20, 1, 11, "clean press");
    expect_q(1'b1, "clean toggle");
  endtask

  task automatic test_window_boundary();
    press(1'b1, 1'b1, 7, 0, 0, "7-cycle press");
    expect_q(1'b1, "7-cycle q hold");
    press(1'b1, 1'b1, 8, 1, 11, "8-cycle press");
    expect_q(1'b0, "8-cycle toggle");
  endtask

  task automatic test_jk_table();
    press(1'b0, 1'b0, 20, 1, 11, "jk00");
    expect_q(1'b0, "jk00 hold");
    press(1'b1, 1'b0, 20, 1, 11, "jk10");
    expect_q(1'b1, "jk10 set");
    press(1'b0, 1'b1, 20, 1, 11, "jk01");
    expect_q(1'b0, "jk01 reset");
    press(1'b1, 1'b1, 20, 1, 11, "jk11");
    expect_q(1'b1, "jk11 toggle");
  endtask

  task automatic test_bouncy_press();
    int pulses = 0;
    int first  = -1;
    bus.j   = 1'b1;
    bus.k   = 1'b1;
    bus.key = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c % 3 == 0) bus.key = ~bus.key;
      tick();
      if (bus.key_pulse === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL bounce pulses: got %0d expected 0", pulses);
    end
    bus.key = 1'b1;
    pulses  = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.key_pulse === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    n_vec++;
    if (pulses != 1 || first != 11) begin
      n_err++;
      $display("FAIL bounce settle: pulses=%0d at cycle %0d expected 1 at 11", pulses, first);
    end
    expect_q(1'b0, "bounce toggle");
    bus.key = 1'b0;
    for (int c = 0; c < 15; c++) tick();
  endtask

  task automatic test_set();
    bus.set = 1'b0;
    #1;
    expect_q(1'b1, "set immediate");
    press(1'b0, 1'b1, 20, 1, 11, "press under set");
    expect_q(1'b1, "set holds q");
    bus.set = 1'b1;
    tick();
    expect_q(1'b1, "set released");
    press(1'b0, 1'b1, 20, 1, 11, "press after set");
    expect_q(1'b0, "jk01 after set");
  endtask

  task automatic test_reset_mid_debounce();
    int pulses = 0;
    press(1'b1, 1'b0, 20, 1, 11, "preload q");
    expect_q(1'b1, "preload q value");
    bus.key = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    rst     = 1'b0;
    bus.key = 1'b0;
    #1;
    expect_q(1'b0, "async rst clears q");
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.key_pulse === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL aborted press pulses: got %0d expected 0", pulses);
    end
    expect_q(1'b0, "q after aborted press");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_window_boundary();
    test_jk_table();
    test_bouncy_press();
    test_set();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
